// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among N_REQ requesters, with registered return tagging.
// Define FIFO_RD_ARB_BURST_EN to hold a grant for up to BURST_LEN consecutive pops.
module fifo_rd_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic [N_REQ-1:0]         i_req,
   output logic [N_REQ-1:0]         o_gnt,
   input  logic                     i_fifo_empty,
   output logic                     o_fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]    i_fifo_rdata,
   output logic [DATA_WIDTH-1:0]    o_rdata,
   output logic                     o_rvalid,
   output logic [$clog2(N_REQ)-1:0] o_rid
);

   localparam int IDX_W = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
      $error("fifo_rd_arbiter: N_REQ out of range");
   end
   if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
      $error("fifo_rd_arbiter: BURST_LEN out of range");
   end

   logic [IDX_W-1:0] prio_ptr_q, prio_ptr_d;
   logic [IDX_W-1:0] search_start;
   logic [IDX_W-1:0] gnt_idx;
   logic             req_found;
   logic             grant_vld;
   logic             rvalid_q;
   logic [IDX_W-1:0] rid_q;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(N_REQ - 1)) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

   // First requester at or after search_start, wrapping modulo N_REQ.
   always_comb begin
      gnt_idx   = '0;
      req_found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         int j;
         j = int'(search_start) + i;
         if (j >= N_REQ) begin
            j = j - N_REQ;
         end
         if (!req_found && i_req[j]) begin
            req_found = 1'b1;
            gnt_idx   = IDX_W'(j);
         end
      end
   end

   assign grant_vld = req_found && !i_fifo_empty;

   always_comb begin
      o_gnt = '0;
      if (grant_vld) begin
         o_gnt[gnt_idx] = 1'b1;
      end
   end

   assign o_fifo_rd_en = grant_vld;

`ifdef FIFO_RD_ARB_BURST_EN
   logic             lock_q, lock_d;
   logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [7:0]       cnt_new;

   // While locked the search starts at the owner, so it keeps winning as long as it requests.
   assign search_start = lock_q ? lock_idx_q : prio_ptr_q;

   always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      cnt_d      = cnt_q;
      prio_ptr_d = prio_ptr_q;
      cnt_new    = '0;
      if (!i_fifo_empty) begin
         if (lock_q && !i_req[lock_idx_q]) begin
            lock_d     = 1'b0;
            cnt_d      = '0;
            prio_ptr_d = next_idx(lock_idx_q);
         end
         if (grant_vld) begin
            cnt_new = ((lock_q && gnt_idx == lock_idx_q) ? cnt_q : 8'd0) + 8'd1;
            if (cnt_new >= 8'(BURST_LEN)) begin
               lock_d     = 1'b0;
               cnt_d      = '0;
               prio_ptr_d = next_idx(gnt_idx);
            end else begin
               lock_d     = 1'b1;
               lock_idx_d = gnt_idx;
               cnt_d      = cnt_new;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         cnt_q      <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         cnt_q      <= cnt_d;
      end
   end
`else
   assign search_start = prio_ptr_q;

   always_comb begin
      prio_ptr_d = prio_ptr_q;
      if (grant_vld) begin
         prio_ptr_d = next_idx(gnt_idx);
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         prio_ptr_q <= '0;
         rvalid_q   <= 1'b0;
         rid_q      <= '0;
      end else begin
         prio_ptr_q <= prio_ptr_d;
         rvalid_q   <= grant_vld;
         if (grant_vld) begin
            rid_q <= gnt_idx;
         end
      end
   end

   assign o_rvalid = rvalid_q;
   assign o_rid    = rid_q;
   assign o_rdata  = rvalid_q ? i_fifo_rdata : '0;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: expected grants are table constants, returned tags go through a scoreboard queue.
module tb_fifo_rd_arbiter;

   logic       clk;
   logic       rstn;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       empty;
   logic       rd_en;
   logic [7:0] rdata_in;
   logic [7:0] rdata;
   logic       rvalid;
   logic [1:0] rid;

   int checks = 0;
   int errors = 0;
   logic [1:0] sb[$];
   logic [1:0] last_rid = 2'd0;
   logic [7:0] dat = 8'h00;

`ifdef FIFO_RD_ARB_BURST_EN
   localparam logic [3:0] PRE_RST_GNT = 4'b0010;
`else
   localparam logic [3:0] PRE_RST_GNT = 4'b0100;
`endif

   fifo_rd_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .BURST_LEN(3)) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_req        (req),
      .o_gnt        (gnt),
      .i_fifo_empty (empty),
      .o_fifo_rd_en (rd_en),
      .i_fifo_rdata (rdata_in),
      .o_rdata      (rdata),
      .o_rvalid     (rvalid),
      .o_rid        (rid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: drive at negedge, check returned word from the previous pop, then this cycle's grant.
   task automatic step(input logic [3:0] r, input logic e, input logic [3:0] exp_gnt);
      logic [1:0] exp_rid;
      @(negedge clk);
      req      = r;
      empty    = e;
      dat      = dat + 8'h11;
      rdata_in = dat;
      #1;
      if (sb.size() > 0) begin
         exp_rid  = sb.pop_front();
         last_rid = exp_rid;
         chk("rvalid", 32'(rvalid), 32'd1);
         chk("rid", 32'(rid), 32'(exp_rid));
         chk("rdata", 32'(rdata), 32'(dat));
      end else begin
         chk("rvalid_idle", 32'(rvalid), 32'd0);
         chk("rid_hold", 32'(rid), 32'(last_rid));
         chk("rdata_zero", 32'(rdata), 32'd0);
      end
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("rd_en", 32'(rd_en), 32'(|exp_gnt));
      if (exp_gnt != 4'b0000) begin
         for (int i = 0; i < 4; i++) begin
            if (exp_gnt[i]) sb.push_back(2'(i));
         end
      end
      $display("step req=%b empty=%b gnt=%b exp_gnt=%b rvalid=%b rid=%0d", r, e, gnt, exp_gnt, rvalid, rid);
   endtask

   initial begin
      rstn     = 1'b0;
      req      = 4'b0000;
      empty    = 1'b1;
      rdata_in = 8'h00;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rid", 32'(rid), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      rstn = 1'b1;

`ifdef FIFO_RD_ARB_BURST_EN
      // Burst of 3 on 0, then 3 on 1, then back to 0.
      step(4'b0011, 1'b0, 4'b0001);
      step(4'b0011, 1'b0, 4'b0001);
      step(4'b0011, 1'b0, 4'b0001);
      step(4'b0011, 1'b0, 4'b0010);
      step(4'b0011, 1'b0, 4'b0010);
      step(4'b0011, 1'b0, 4'b0010);
      step(4'b0011, 1'b0, 4'b0001);
      step(4'b0000, 1'b0, 4'b0000);
      // Burst to 2 interrupted by one empty cycle; 0 keeps requesting.
      step(4'b0101, 1'b0, 4'b0100);
      step(4'b0101, 1'b1, 4'b0000);
      step(4'b0101, 1'b0, 4'b0100);
      step(4'b0101, 1'b0, 4'b0100);
      step(4'b0101, 1'b0, 4'b0001);
      step(4'b0000, 1'b0, 4'b0000);
`else
      step(4'b1111, 1'b0, 4'b0001);
      step(4'b1111, 1'b0, 4'b0010);
      step(4'b1111, 1'b0, 4'b0100);
      step(4'b1111, 1'b0, 4'b1000);
      step(4'b0000, 1'b0, 4'b0000);
      step(4'b0001, 1'b0, 4'b0001);
      step(4'b0101, 1'b0, 4'b0100);
      step(4'b0101, 1'b0, 4'b0001);
      step(4'b1111, 1'b1, 4'b0000);
      step(4'b1111, 1'b0, 4'b0010);
      step(4'b0000, 1'b0, 4'b0000);
`endif

      // Pop, then reset lands before the edge that would return it.
      step(4'b1111, 1'b0, PRE_RST_GNT);
      #3;
      rstn = 1'b0;
      req  = 4'b0000;
      @(negedge clk);
      #1;
      chk("rst_pop_rvalid", 32'(rvalid), 32'd0);
      chk("rst_pop_rid", 32'(rid), 32'd0);
      sb.delete();
      last_rid = 2'd0;
      rstn = 1'b1;
      step(4'b1111, 1'b0, 4'b0001);
      step(4'b0000, 1'b0, 4'b0000);
      step(4'b0000, 1'b0, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of read requesters sharing one FIFO read port; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 8: FIFO word width.
REQ-003 Parameter BURST_LEN, default 4: maximum consecutive reads per grant when burst mode is compiled in; legal range 1..255.
REQ-004 i_clk  in  1  read-domain clock.
REQ-005 i_rstn  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  N_REQ  per-requester read request; level-sensitive.
REQ-007 o_gnt  out  N_REQ  one-hot grant; a bit high means one FIFO word is popped for that requester this cycle.
REQ-008 i_fifo_empty  in  1  registered empty flag from the FIFO read-pointer logic.
REQ-009 o_fifo_rd_en  out  1  FIFO pop strobe.
REQ-010 i_fifo_rdata  in  DATA_WIDTH  FIFO memory read data, valid one cycle after a pop.
REQ-011 o_rdata  out  DATA_WIDTH  returned word.
REQ-012 o_rvalid  out  1  o_rdata valid this cycle.
REQ-013 o_rid  out  clog2(N_REQ)  index of the requester owning o_rdata.

Function
REQ-014 o_gnt is zero when i_fifo_empty=1 or i_req=0, combinationally.
REQ-015 Otherwise exactly one o_gnt bit is high: the first requesting index at or after prio_ptr, searching upward modulo N_REQ.
REQ-016 o_fifo_rd_en is the OR of o_gnt, with no added latency.
REQ-017 On a cycle with a grant to index k and no burst lock, prio_ptr becomes (k+1) mod N_REQ; with no grant, prio_ptr holds.
REQ-018 o_rvalid and o_rid are registered: one cycle after o_fifo_rd_en=1 they are 1 and k; otherwise o_rvalid=0 and o_rid holds.
REQ-019 o_rdata equals i_fifo_rdata while o_rvalid=1 and equals zero otherwise.
REQ-020 Back-to-back pops are allowed every cycle; sustained throughput is one word per clock while the FIFO is non-empty.
REQ-021 A requester dropping i_req in the cycle after its grant still receives the corresponding o_rvalid; already-issued pops are never cancelled.
REQ-022 i_req bits are sampled only in the grant cycle; no request is queued internally.

Reset
REQ-023 Asynchronous assertion of i_rstn=0 clears prio_ptr, o_rvalid, o_rid, the burst counter and the burst lock to 0.
REQ-024 A pop issued in the cycle before reset assertion produces no o_rvalid.
REQ-025 Outputs return to normal operation on the first i_clk edge after deassertion.

Configuration
REQ-026 Macro FIFO_RD_ARB_BURST_EN, when defined, enables burst lock: after a grant to k, lock is held on k and prio_ptr does not advance while i_req[k]=1 and fewer than BURST_LEN grants have been made to k.
REQ-027 Under FIFO_RD_ARB_BURST_EN, on a lock release (BURST_LEN-th grant, or i_req[k]=0), the burst counter clears and prio_ptr becomes (k+1) mod N_REQ.
REQ-028 Under FIFO_RD_ARB_BURST_EN, cycles with i_fifo_empty=1 keep the lock and counter unchanged.
REQ-029 Without FIFO_RD_ARB_BURST_EN, the burst counter and lock do not exist, BURST_LEN is ignored, and every grant rotates prio_ptr per REQ-017.

Verification
REQ-030 Reset, i_req=4'b1111, empty=0 for 4 cycles, macro off -> o_gnt 0001,0010,0100,1000; o_rid 0,1,2,3 one cycle later.
REQ-031 i_req=4'b0101, prio_ptr=1 -> o_gnt=0100, next cycle o_gnt=0001.
REQ-032 i_fifo_empty=1 with i_req=4'b1111 -> o_gnt=0, o_fifo_rd_en=0, o_rvalid=0 next cycle, prio_ptr unchanged.
REQ-033 Macro on, BURST_LEN=3, i_req=4'b0011 held -> o_gnt 0001 x3, then 0010 x3, then 0001.
REQ-034 Macro on, empty toggles 0,1,0 during a burst to index 2 -> grants to 2 resume after the empty cycle, 3 grants total before rotation.
REQ-035 Pop in cycle n, i_rstn low in cycle n+1 -> o_rvalid stays 0; after release o_gnt starts at index 0.
